// File: rtl/issue_scoreboard.sv
// rtl/issue_scoreboard.sv - issue-stage RAW/WAW/structural hazard scoreboard
// Per-register countdown counters track pending writes; a long-unit counter guards the non-pipelined unit.
package issue_scoreboard_pkg;
   typedef enum logic [2:0] {
      OP_NOP = 3'd0,
      OP_ADD = 3'd1,
      OP_SUB = 3'd2,
      OP_AND = 3'd3,
      OP_OR  = 3'd4,
      OP_XOR = 3'd5,
      OP_MUL = 3'd6,
      OP_DIV = 3'd7
   } op_t;
endpackage

module issue_scoreboard
   import issue_scoreboard_pkg::*;
#(
   parameter int NREGS       = 16,
   parameter int ALU_LAT     = 1,
   parameter int LONG_LAT    = 4,
   parameter int R0_ZERO     = 1,
   parameter int STALL_CNT_W = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  op_t                    iss_alu_op,
   input  logic                   iss_long,
   input  logic                   iss_we,
   input  logic [3:0]             iss_rd_addr,
   input  logic [3:0]             iss_rs1_addr,
   input  logic [3:0]             iss_rs2_addr,
   input  logic                   iss_use_imm,
   output logic                   issue_fire,
   output logic                   issue_stall,
   output logic [NREGS-1:0]       busy_vec,
   output logic [STALL_CNT_W-1:0] stall_cycles
);
   localparam int CW = (LONG_LAT > 1) ? $clog2(LONG_LAT) : 1;
   localparam logic [CW-1:0] LONG_LD = CW'(LONG_LAT - 1);
   localparam logic [CW-1:0] ALU_LD  = CW'(ALU_LAT - 1);

   logic [CW-1:0]          r_cnt [NREGS];
   logic [CW-1:0]          r_long_cnt;
   logic [STALL_CNT_W-1:0] r_stall_cycles;

   logic [NREGS-1:0] w_hazard_busy;
   logic [CW-1:0]    w_lat;
   logic             w_valid;
   logic             w_raw;
   logic             w_waw;
   logic             w_struct;
   logic             w_rd_valid;
   logic             w_fire;
   logic             w_stall;

   // r0 is excluded from hazard detection but still reported by busy_vec (it is never loaded anyway).
   always_comb begin
      w_hazard_busy = '0;
      busy_vec      = '0;
      for (int r = 0; r < NREGS; r++) begin
         busy_vec[r]      = (r_cnt[r] != '0);
         w_hazard_busy[r] = (r_cnt[r] != '0) && !((R0_ZERO != 0) && (r == 0));
      end
   end

   always_comb begin
      w_lat      = iss_long ? LONG_LD : ALU_LD;
      w_valid    = (iss_alu_op != OP_NOP) && !flush;
      w_raw      = w_hazard_busy[iss_rs1_addr] || (!iss_use_imm && w_hazard_busy[iss_rs2_addr]);
      w_waw      = iss_we && w_hazard_busy[iss_rd_addr] && (r_cnt[iss_rd_addr] > w_lat);
      w_struct   = iss_long && (r_long_cnt != '0);
      w_rd_valid = iss_we && !((R0_ZERO != 0) && (iss_rd_addr == 4'd0));
      w_stall    = !rst && w_valid && (w_raw || w_waw || w_struct);
      w_fire     = !rst && w_valid && !(w_raw || w_waw || w_struct);
   end

   assign issue_stall  = w_stall;
   assign issue_fire   = w_fire;
   assign stall_cycles = r_stall_cycles;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NREGS; r++) r_cnt[r] <= '0;
         r_long_cnt     <= '0;
         r_stall_cycles <= '0;
      end else begin
         for (int r = 0; r < NREGS; r++) begin
            if (w_fire && w_rd_valid && (iss_rd_addr == 4'(r)))
               r_cnt[r] <= w_lat;
            else if (r_cnt[r] != '0)
               r_cnt[r] <= r_cnt[r] - 1'b1;
         end
         if (w_fire && iss_long)
            r_long_cnt <= LONG_LD;
         else if (r_long_cnt != '0)
            r_long_cnt <= r_long_cnt - 1'b1;
         if (w_stall && (r_stall_cycles != '1))
            r_stall_cycles <= r_stall_cycles + 1'b1;
      end
   end
endmodule

// File: tb/tb_issue_scoreboard.sv
// tb/tb_issue_scoreboard.sv - directed self-checking bench for issue_scoreboard
module tb_issue_scoreboard;
   import issue_scoreboard_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   op_t         iss_alu_op = OP_NOP;
   logic        iss_long = 1'b0;
   logic        iss_we = 1'b0;
   logic [3:0]  iss_rd_addr = '0;
   logic [3:0]  iss_rs1_addr = '0;
   logic [3:0]  iss_rs2_addr = '0;
   logic        iss_use_imm = 1'b0;
   logic        issue_fire;
   logic        issue_stall;
   logic [15:0] busy_vec;
   logic [31:0] stall_cycles;

   int n_tests = 0;
   int n_fail  = 0;

   issue_scoreboard dut (
      .clk(clk), .rst(rst), .flush(flush), .iss_alu_op(iss_alu_op), .iss_long(iss_long),
      .iss_we(iss_we), .iss_rd_addr(iss_rd_addr), .iss_rs1_addr(iss_rs1_addr),
      .iss_rs2_addr(iss_rs2_addr), .iss_use_imm(iss_use_imm), .issue_fire(issue_fire),
      .issue_stall(issue_stall), .busy_vec(busy_vec), .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input op_t op, input logic lng, input logic we, input logic [3:0] rd,
                        input logic [3:0] rs1, input logic [3:0] rs2, input logic imm);
      iss_alu_op = op; iss_long = lng; iss_we = we; iss_rd_addr = rd;
      iss_rs1_addr = rs1; iss_rs2_addr = rs2; iss_use_imm = imm;
   endtask

   task automatic drain();
      drive(OP_NOP, 0, 0, 0, 0, 0, 0);
      repeat (5) step();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(OP_ADD, 0, 1, 4'd1, 4'd2, 4'd3, 0);
      step();
      n_tests++; if (issue_fire !== 1'b0) begin n_fail++; $display("FAIL reset_fire_forced: got %b want 0", issue_fire); end
      step();
      rst = 1'b0;
      drive(OP_NOP, 0, 0, 0, 0, 0, 0);
      #1;
      n_tests++; if (busy_vec !== 16'h0) begin n_fail++; $display("FAIL reset_busy: got %h want 0000", busy_vec); end
      n_tests++; if (stall_cycles !== 32'd0) begin n_fail++; $display("FAIL reset_stall_cycles: got %0d want 0", stall_cycles); end
      n_tests++; if (issue_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", issue_stall); end
      n_tests++; if (issue_fire !== 1'b0) begin n_fail++; $display("FAIL reset_fire: got %b want 0", issue_fire); end
   endtask

   task automatic test_raw_long();
      drive(OP_MUL, 1, 1, 4'd3, 4'd1, 4'd1, 1);
      #1;
      n_tests++; if (issue_fire !== 1'b1) begin n_fail++; $display("FAIL raw_long_fire: got %b want 1", issue_fire); end
      step();
      drive(OP_ADD, 0, 1, 4'd4, 4'd3, 4'd0, 1);
      #1;
      for (int k = 1; k <= 3; k++) begin
         n_tests++; if (issue_stall !== 1'b1 || issue_fire !== 1'b0) begin
            n_fail++; $display("FAIL raw_stall t+%0d: stall=%b fire=%b want stall=1 fire=0", k, issue_stall, issue_fire); end
         step();
      end
      n_tests++; if (issue_fire !== 1'b1 || issue_stall !== 1'b0) begin
         n_fail++; $display("FAIL raw_fire t+4: fire=%b stall=%b want fire=1 stall=0", issue_fire, issue_stall); end
      n_tests++; if (stall_cycles !== 32'd3) begin n_fail++; $display("FAIL raw_stall_cycles: got %0d want 3", stall_cycles); end
      drain();
   endtask

   task automatic test_alu_forward();
      drive(OP_ADD, 0, 1, 4'd5, 4'd1, 4'd0, 1);
      #1;
      n_tests++; if (issue_fire !== 1'b1) begin n_fail++; $display("FAIL alu_first_fire: got %b want 1", issue_fire); end
      step();
      drive(OP_SUB, 0, 1, 4'd6, 4'd1, 4'd5, 0);
      #1;
      n_tests++; if (issue_fire !== 1'b1 || issue_stall !== 1'b0) begin
         n_fail++; $display("FAIL alu_second_fire: fire=%b stall=%b want fire=1 stall=0", issue_fire, issue_stall); end
      n_tests++; if (busy_vec !== 16'h0) begin n_fail++; $display("FAIL alu_busy: got %h want 0000", busy_vec); end
      drain();
   endtask

   task automatic test_imm_masks_rs2();
      drive(OP_DIV, 1, 1, 4'd6, 4'd1, 4'd1, 1);
      #1;
      n_tests++; if (issue_fire !== 1'b1) begin n_fail++; $display("FAIL imm_long_fire: got %b want 1", issue_fire); end
      step();
      n_tests++; if (busy_vec !== 16'h0040) begin n_fail++; $display("FAIL imm_busy6: got %h want 0040", busy_vec); end
      drive(OP_ADD, 0, 1, 4'd7, 4'd1, 4'd6, 1);
      #1;
      n_tests++; if (issue_fire !== 1'b1 || issue_stall !== 1'b0) begin
         n_fail++; $display("FAIL imm_fire: fire=%b stall=%b want fire=1 stall=0", issue_fire, issue_stall); end
      drain();
   endtask

   task automatic test_back_to_back_long();
      drive(OP_MUL, 1, 1, 4'd7, 4'd1, 4'd0, 1);
      #1;
      n_tests++; if (issue_fire !== 1'b1) begin n_fail++; $display("FAIL struct_first_fire: got %b want 1", issue_fire); end
      step();
      drive(OP_MUL, 1, 1, 4'd8, 4'd9, 4'd0, 1);
      #1;
      for (int k = 1; k <= 3; k++) begin
         n_tests++; if (issue_stall !== 1'b1 || issue_fire !== 1'b0) begin
            n_fail++; $display("FAIL struct_stall t+%0d: stall=%b fire=%b want stall=1 fire=0", k, issue_stall, issue_fire); end
         step();
      end
      n_tests++; if (issue_fire !== 1'b1) begin n_fail++; $display("FAIL struct_fire t+4: got %b want 1", issue_fire); end
      n_tests++; if (stall_cycles !== 32'd6) begin n_fail++; $display("FAIL struct_stall_cycles: got %0d want 6", stall_cycles); end
      drain();
   endtask

   task automatic test_waw_flush();
      drive(OP_MUL, 1, 1, 4'd2, 4'd1, 4'd0, 1);
      #1;
      n_tests++; if (issue_fire !== 1'b1) begin n_fail++; $display("FAIL waw_long_fire: got %b want 1", issue_fire); end
      step();
      drive(OP_ADD, 0, 1, 4'd2, 4'd1, 4'd0, 1);
      #1;
      n_tests++; if (issue_stall !== 1'b1) begin n_fail++; $display("FAIL waw_stall t+1: got %b want 1", issue_stall); end
      step();
      flush = 1'b1;
      #1;
      n_tests++; if (issue_stall !== 1'b0 || issue_fire !== 1'b0) begin
         n_fail++; $display("FAIL flush_outputs t+2: stall=%b fire=%b want 0 0", issue_stall, issue_fire); end
      n_tests++; if (busy_vec[2] !== 1'b1) begin n_fail++; $display("FAIL flush_busy2 t+2: got %b want 1", busy_vec[2]); end
      step();
      flush = 1'b0;
      drive(OP_NOP, 0, 0, 0, 0, 0, 0);
      #1;
      n_tests++; if (busy_vec[2] !== 1'b1) begin n_fail++; $display("FAIL flush_busy2 t+3: got %b want 1", busy_vec[2]); end
      n_tests++; if (stall_cycles !== 32'd7) begin n_fail++; $display("FAIL flush_stall_cycles: got %0d want 7", stall_cycles); end
      step();
      n_tests++; if (busy_vec[2] !== 1'b0) begin n_fail++; $display("FAIL flush_busy2 t+4: got %b want 0", busy_vec[2]); end
      drain();
   endtask

   task automatic test_r0_zero();
      drive(OP_MUL, 1, 1, 4'd0, 4'd1, 4'd0, 1);
      #1;
      n_tests++; if (issue_fire !== 1'b1) begin n_fail++; $display("FAIL r0_long_fire: got %b want 1", issue_fire); end
      step();
      n_tests++; if (busy_vec !== 16'h0) begin n_fail++; $display("FAIL r0_busy: got %h want 0000", busy_vec); end
      drive(OP_ADD, 0, 1, 4'd1, 4'd0, 4'd0, 0);
      #1;
      n_tests++; if (issue_fire !== 1'b1 || issue_stall !== 1'b0) begin
         n_fail++; $display("FAIL r0_read_fire: fire=%b stall=%b want fire=1 stall=0", issue_fire, issue_stall); end
      drain();
   endtask

   task automatic test_nop_bubble();
      drive(OP_MUL, 1, 1, 4'd3, 4'd1, 4'd0, 1);
      step();
      drive(OP_NOP, 0, 1, 4'd3, 4'd3, 4'd3, 0);
      #1;
      n_tests++; if (issue_stall !== 1'b0 || issue_fire !== 1'b0) begin
         n_fail++; $display("FAIL nop_outputs: stall=%b fire=%b want 0 0", issue_stall, issue_fire); end
      step();
      n_tests++; if (busy_vec !== 16'h0008) begin n_fail++; $display("FAIL nop_busy3: got %h want 0008", busy_vec); end
      step(); step();
      n_tests++; if (busy_vec !== 16'h0) begin n_fail++; $display("FAIL nop_decrement_done: got %h want 0000", busy_vec); end
      n_tests++; if (stall_cycles !== 32'd7) begin n_fail++; $display("FAIL nop_stall_cycles: got %0d want 7", stall_cycles); end
      drain();
   endtask

   task automatic test_reset_mid_op();
      drive(OP_DIV, 1, 1, 4'd4, 4'd1, 4'd0, 1);
      step();
      drive(OP_ADD, 0, 1, 4'd5, 4'd4, 4'd0, 1);
      rst = 1'b1;
      #1;
      n_tests++; if (issue_stall !== 1'b0 || issue_fire !== 1'b0) begin
         n_fail++; $display("FAIL rst_mid_outputs: stall=%b fire=%b want 0 0", issue_stall, issue_fire); end
      step();
      rst = 1'b0;
      #1;
      n_tests++; if (busy_vec !== 16'h0) begin n_fail++; $display("FAIL rst_mid_busy: got %h want 0000", busy_vec); end
      n_tests++; if (stall_cycles !== 32'd0) begin n_fail++; $display("FAIL rst_mid_stall_cycles: got %0d want 0", stall_cycles); end
      n_tests++; if (issue_fire !== 1'b1) begin n_fail++; $display("FAIL rst_mid_refire: got %b want 1", issue_fire); end
      drain();
   endtask

   initial begin
      test_reset();
      test_raw_long();
      test_alu_forward();
      test_imm_masks_rs2();
      test_back_to_back_long();
      test_waw_flush();
      test_r0_zero();
      test_nop_bubble();
      test_reset_mid_op();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
